sim_end_monitor: RTL
====================

Name: sim_end_monitor

Overview:
- Simulation-only end-of-test monitor for the SoC sim top; replaces the ad-hoc pass/fail and signature-dump logic in the sim top with one parametrised, cycle-accurate block.
- Watches the per-hart result words (CSR-based end/success flags plus the fail test number in gp) for NUM_HARTS cores and applies a cycle-count watchdog.
- In compliance mode, walks the signature region through a single-outstanding memory read port and streams the words out.
- The sim top performs all $display/$finish calls from this block's outputs.

Parameters:
NUM_HARTS, 1, number of monitored harts (1..8)
COMPLIANCE, 0, 0 = ISA/user-program pass-fail mode; 1 = signature-dump mode
STOP_ON_FAIL, 1, ISA mode: finish on first failing hart instead of waiting for all harts
TIMEOUT_CYCLES, 0, watchdog limit in cycles after reset; 0 disables
CNT_W, 32, width of cycle counter
MEM_AW, 30, word-address width of memory read port

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
status_i  in  32*NUM_HARTS  per-hart result word; bit0 = end, bit1 = success
fail_num_i  in  32*NUM_HARTS  per-hart fail test number (gp)
end_flag_i  in  32  compliance end flag word
sig_begin_i  in  32  signature begin byte address
sig_end_i  in  32  signature end byte address (exclusive)
mem_req_o  out  1  read request
mem_addr_o  out  MEM_AW  word address (byte address [MEM_AW+1:2])
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data
sig_valid_o  out  1  one-cycle strobe per signature word
sig_data_o  out  32  signature word
done_o  out  1  sticky; test finished
pass_o  out  1  valid when done_o
timeout_o  out  1  sticky; watchdog fired
fail_hart_o  out  3  index of first failing hart
fail_num_o  out  32  fail_num of that hart, captured at its end edge
cycle_cnt_o  out  CNT_W  cycles since reset; freezes at done; saturates at all-ones

Behaviour:
- Reset (rst_i high at clk edge): all outputs 0. FSM to IDLE. Per-hart end_q, ended, and failed flags cleared. cycle_cnt 0.
- Reset asserted mid-operation aborts any dump. An outstanding rvalid arriving after reset is ignored.
- ISA mode, end detection: a hart's end edge = status[0]=1 and end_q=0 (end_q registered each cycle). On the edge, set ended[h]; if status[1]=0, set failed[h].
- ISA mode, first failure: fail_hart_o/fail_num_o capture the first failing hart only. On simultaneous failing edges, the lowest index wins.
- ISA mode, done: done_o rises the cycle after the last ended[h] sets. With STOP_ON_FAIL=1, done_o also rises the cycle after the first failure.
- ISA mode, pass: pass_o = all harts ended and none failed. Later edges after done are ignored.
- Compliance mode, IDLE: on end_flag_i==1 with the registered previous end_flag != 1, latch ptr = sig_begin_i[31:2] and lim = sig_end_i. If ptr*4 >= lim, go to FIN; else go to REQ.
- Compliance mode, REQ: mem_req_o=1 and mem_addr_o=ptr, held stable until mem_gnt_i; then go to WAIT with mem_req_o=0.
- Compliance mode, WAIT: on mem_rvalid_i, sig_valid_o=1 and sig_data_o=mem_rdata_i for one cycle; ptr+1. If (ptr+1)*4 >= lim, go to FIN; else go to REQ. Only one request is ever outstanding.
- Compliance mode, FIN: next cycle done_o=1, pass_o=1. Stays in FIN until reset.
- Watchdog: if TIMEOUT_CYCLES != 0 and cycle_cnt reaches TIMEOUT_CYCLES with done_o=0, then done_o=1, timeout_o=1, pass_o=0, and any dump is abandoned (mem_req_o dropped).
- Simultaneous timeout and completion in the same cycle: completion wins, timeout_o=0.
- done_o, pass_o, timeout_o are sticky until reset.

Test Plan:
- ISA, NUM_HARTS=1: status_i 0 -> 0x3 at cycle 50 -> done_o=1 and pass_o=1 at cycle 51; cycle_cnt_o frozen at 51.
- ISA, NUM_HARTS=4, STOP_ON_FAIL=1: harts 2 and 1 assert status 0x1 on the same cycle with fail_num 7 and 9 -> fail_hart_o=1, fail_num_o=9, pass_o=0 the next cycle.
- ISA, NUM_HARTS=2, STOP_ON_FAIL=0: hart0 0x3 at cycle 10, hart1 0x3 at cycle 30 -> done_o rises at cycle 31 only; status held high produces no repeated edge.
- Compliance: begin=0x100, end=0x10C, memory grants with 2-cycle gnt delay and 3-cycle rvalid latency -> exactly 3 sig_valid_o strobes with addresses 0x40, 0x41, 0x42 in order, then done_o=1 and pass_o=1. Repeat with begin=end -> zero strobes, done_o next cycle.
- Watchdog TIMEOUT_CYCLES=100, no end -> done_o=1, timeout_o=1, pass_o=0 when cycle_cnt_o=100. Variant with end edge exactly at the timeout cycle -> timeout_o=0.
- Reset mid-dump: rst_i asserted during WAIT -> the next cycle shows all outputs 0 and FSM in IDLE; a late rvalid produces no sig_valid_o; a fresh end_flag 0->1 edge restarts the dump from begin.

Source files
------------

// File: rtl/sim_end_monitor.sv
// End-of-test monitor for the SoC sim top. It detects per-hart pass/fail, runs a cycle watchdog
// and streams the compliance signature through a single-outstanding read port.
module sim_end_monitor #(
  parameter int unsigned NUM_HARTS      = 1,
  parameter int unsigned COMPLIANCE     = 0,
  parameter int unsigned STOP_ON_FAIL   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned MEM_AW         = 30
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [32*NUM_HARTS-1:0] status_i,
  input  logic [32*NUM_HARTS-1:0] fail_num_i,
  input  logic [31:0]             end_flag_i,
  input  logic [31:0]             sig_begin_i,
  input  logic [31:0]             sig_end_i,
  output logic                    mem_req_o,
  output logic [MEM_AW-1:0]       mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i,
  output logic                    sig_valid_o,
  output logic [31:0]             sig_data_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    timeout_o,
  output logic [2:0]              fail_hart_o,
  output logic [31:0]             fail_num_o,
  output logic [CNT_W-1:0]        cycle_cnt_o
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StFin, StAbort} state_e;

  state_e               r_state, w_state_d;
  logic [NUM_HARTS-1:0] r_end_q, w_end_q_d;
  logic [NUM_HARTS-1:0] r_ended, w_ended_d;
  logic [NUM_HARTS-1:0] r_failed, w_failed_d;
  logic [NUM_HARTS-1:0] w_edge, w_fail_edge;
  logic [31:0]          r_end_flag_q;
  logic [29:0]          r_ptr, w_ptr_d;
  logic [31:0]          r_lim, w_lim_d;
  logic [30:0]          w_ptr_inc;
  logic [32:0]          w_nxt_byte;
  logic                 r_sig_valid, w_sig_valid_d;
  logic [31:0]          r_sig_data, w_sig_data_d;
  logic                 r_done, w_done_d;
  logic                 r_pass, w_pass_d;
  logic                 r_timeout, w_timeout_d;
  logic [2:0]           r_fail_hart, w_fail_hart_d;
  logic [31:0]          r_fail_num, w_fail_num_d;
  logic [CNT_W-1:0]     r_cnt, w_cnt_d;
  logic                 w_complete, w_complete_pass, w_timeout_hit, w_trigger;
  logic                 w_unused;

  assign w_unused = ^{status_i, fail_num_i, sig_begin_i[1:0], r_ptr};

  always_comb begin
    w_cnt_d         = r_cnt;
    w_end_q_d       = '0;
    w_edge          = '0;
    w_fail_edge     = '0;
    w_ended_d       = r_ended;
    w_failed_d      = r_failed;
    w_fail_hart_d   = r_fail_hart;
    w_fail_num_d    = r_fail_num;
    w_state_d       = r_state;
    w_ptr_d         = r_ptr;
    w_lim_d         = r_lim;
    w_sig_valid_d   = 1'b0;
    w_sig_data_d    = r_sig_data;
    w_complete      = 1'b0;
    w_complete_pass = 1'b0;
    w_ptr_inc       = {1'b0, r_ptr} + 31'd1;
    w_nxt_byte      = {w_ptr_inc, 2'b00};
    w_trigger       = (end_flag_i == 32'd1) && (r_end_flag_q != 32'd1) && !r_done;

    if (!r_done && !(&r_cnt)) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end

    for (int h = 0; h < int'(NUM_HARTS); h++) begin
      w_end_q_d[h] = status_i[32*h];
    end

    if (COMPLIANCE == 0) begin
      if (!r_done) begin
        for (int h = 0; h < int'(NUM_HARTS); h++) begin
          w_edge[h]      = status_i[32*h] & ~r_end_q[h];
          w_fail_edge[h] = w_edge[h] & ~status_i[32*h+1];
        end
        w_ended_d  = r_ended | w_edge;
        w_failed_d = r_failed | w_fail_edge;
        // Descending scan so the lowest failing index is the one left standing.
        if (r_failed == '0) begin
          for (int h = int'(NUM_HARTS) - 1; h >= 0; h--) begin
            if (w_fail_edge[h]) begin
              w_fail_hart_d = 3'(h);
              w_fail_num_d  = fail_num_i[32*h +: 32];
            end
          end
        end
        w_complete      = (&w_ended_d) | ((STOP_ON_FAIL != 0) & (|w_failed_d));
        w_complete_pass = (&w_ended_d) & ~(|w_failed_d);
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_trigger) begin
            w_ptr_d   = sig_begin_i[31:2];
            w_lim_d   = sig_end_i;
            w_state_d = ({sig_begin_i[31:2], 2'b00} >= sig_end_i) ? StFin : StReq;
          end
        end
        StReq: begin
          if (mem_gnt_i) w_state_d = StWait;
        end
        StWait: begin
          if (mem_rvalid_i) begin
            w_sig_valid_d = 1'b1;
            w_sig_data_d  = mem_rdata_i;
            w_ptr_d       = w_ptr_inc[29:0];
            w_state_d     = (w_nxt_byte >= {1'b0, r_lim}) ? StFin : StReq;
          end
        end
        StFin: begin
          w_complete      = 1'b1;
          w_complete_pass = 1'b1;
        end
        StAbort: ;
        default: w_state_d = StIdle;
      endcase
    end

    // Completion on the same edge as the watchdog takes priority.
    w_timeout_hit = (TIMEOUT_CYCLES != 0) && !r_done && !w_complete &&
                    (w_cnt_d == CNT_W'(TIMEOUT_CYCLES));

    w_done_d    = r_done;
    w_pass_d    = r_pass;
    w_timeout_d = r_timeout;
    if (!r_done && w_complete) begin
      w_done_d = 1'b1;
      w_pass_d = w_complete_pass;
    end else if (w_timeout_hit) begin
      w_done_d    = 1'b1;
      w_timeout_d = 1'b1;
      w_pass_d    = 1'b0;
      if (COMPLIANCE != 0) begin
        w_state_d     = StAbort;
        w_sig_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_end_q      <= '0;
      r_ended      <= '0;
      r_failed     <= '0;
      r_end_flag_q <= '0;
      r_ptr        <= '0;
      r_lim        <= '0;
      r_sig_valid  <= 1'b0;
      r_sig_data   <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_fail_hart  <= '0;
      r_fail_num   <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_d;
      r_end_q      <= w_end_q_d;
      r_ended      <= w_ended_d;
      r_failed     <= w_failed_d;
      r_end_flag_q <= end_flag_i;
      r_ptr        <= w_ptr_d;
      r_lim        <= w_lim_d;
      r_sig_valid  <= w_sig_valid_d;
      r_sig_data   <= w_sig_data_d;
      r_done       <= w_done_d;
      r_pass       <= w_pass_d;
      r_timeout    <= w_timeout_d;
      r_fail_hart  <= w_fail_hart_d;
      r_fail_num   <= w_fail_num_d;
      r_cnt        <= w_cnt_d;
    end
  end

  assign mem_req_o   = (r_state == StReq);
  assign mem_addr_o  = MEM_AW'(r_ptr);
  assign sig_valid_o = r_sig_valid;
  assign sig_data_o  = r_sig_data;
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign timeout_o   = r_timeout;
  assign fail_hart_o = r_fail_hart;
  assign fail_num_o  = r_fail_num;
  assign cycle_cnt_o = r_cnt;

endmodule
